cipher_sched: RTL and testbench

CIPHER_SCHED -- requirements
Module: cipher_sched

---
 rtl/cipher_pkg.sv | 23 ++
 rtl/rr_pick.sv | 43 ++++
 rtl/cipher_sched.sv | 198 +++++++++++++++++++
 tb/tb_cipher_sched.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cipher_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cipher_pkg
// Description : Shared types and constants for the cipher request scheduler:
//               the scheduler state encoding, datapath width and default
//               requester count.
// Revision    : 1.0 - initial release
// ============================================================================
package cipher_pkg;

  localparam int DATA_W       = 8;
  localparam int NREQ_DEFAULT = 4;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    WAIT_DONE = 3'd2,
    RELEASE   = 3'd3,
    RESP      = 3'd4
  } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker. Scans the request vector
//               starting at ptr, wrapping at NREQ, and returns the first set
//               request as a one-hot grant plus its binary index.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
  import cipher_pkg::*;
#(
  parameter int NREQ  = NREQ_DEFAULT,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Walk the requesters in priority order ptr, ptr+1, ... and keep the first hit.
  always_comb begin : p_pick
    int w_pos;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    w_pos = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_pos = int'(ptr) + k;
      if (w_pos >= NREQ) begin
        w_pos = w_pos - NREQ;
      end
      if (!any && req[w_pos]) begin
        any          = 1'b1;
        grant[w_pos] = 1'b1;
        idx          = IDX_W'(w_pos);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/cipher_sched.sv
`default_nettype none
// ============================================================================
// Module      : cipher_sched
// Description : Round-robin scheduler that hands one requester at a time to a
//               start/done handshaked cipher engine and returns the result on
//               a valid/ready response port.
//               Build option CIPHER_SCHED_TIMEOUT_EN: bounds the wait for
//               eng_done to TIMEOUT cycles and flags expiry on rsp_err.
// Revision    : 1.0 - initial release
// ============================================================================
module cipher_sched
  import cipher_pkg::*;
#(
  parameter int NREQ    = NREQ_DEFAULT,
  parameter int TIMEOUT = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*DATA_W-1:0]   req_key,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [DATA_W-1:0]        rsp_data,
  output logic                     rsp_err,
  output logic                     eng_start,
  output logic [DATA_W-1:0]        eng_key,
  output logic [DATA_W-1:0]        eng_plaintext,
  input  logic                     eng_done,
  input  logic [DATA_W-1:0]        eng_ciphertext,
  output logic                     busy
);

  localparam int c_IDX_W = $clog2(NREQ);

  sched_state_t        r_state;
  sched_state_t        w_state_nxt;
  logic [c_IDX_W-1:0]  r_ptr;
  logic [c_IDX_W-1:0]  r_id;
  logic [c_IDX_W-1:0]  w_idx;
  logic [NREQ-1:0]     w_grant;
  logic [NREQ-1:0]     w_req_ready;
  logic                w_any;
  logic                w_accept;
  logic                w_eng_start;
  logic                w_tmo_hit;
  logic [DATA_W-1:0]   r_key;
  logic [DATA_W-1:0]   r_pt;
  logic [DATA_W-1:0]   r_rsp_data;

  rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (c_IDX_W)
  ) u_rr_pick (
    .req   (req_valid),
    .ptr   (r_ptr),
    .grant (w_grant),
    .idx   (w_idx),
    .any   (w_any)
  );

  // Scopes only an out-of-range TIMEOUT; legal values elaborate to nothing.
  generate
    if (TIMEOUT < 1) begin : g_timeout_range_bad
    end
  endgenerate

  assign w_accept = (r_state == IDLE) && w_any && rst_n;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state plus the grant pulse and engine start level.
  always_comb begin
    w_state_nxt = r_state;
    w_req_ready = '0;
    w_eng_start = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_req_ready = w_grant;
          w_state_nxt = START;
        end
      end
      START: begin
        w_eng_start = 1'b1;
        w_state_nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        w_eng_start = 1'b1;
        if (eng_done || w_tmo_hit) begin
          w_state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        // Wait for the engine to drop done so a stale level never leaks
        // into the next transaction.
        if (!eng_done) begin
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Capture the granted payload and index; advance the pointer on handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key <= '0;
      r_pt  <= '0;
      r_id  <= '0;
      r_ptr <= '0;
    end else begin
      if (w_accept) begin
        r_key <= req_key[int'(w_idx)*DATA_W +: DATA_W];
        r_pt  <= req_data[int'(w_idx)*DATA_W +: DATA_W];
        r_id  <= w_idx;
      end
      if ((r_state == RESP) && rsp_ready) begin
        r_ptr <= (r_id == c_IDX_W'(NREQ - 1)) ? '0 : r_id + 1'b1;
      end
    end
  end

`ifdef CIPHER_SCHED_TIMEOUT_EN
  localparam int c_TMO_W = $clog2(TIMEOUT + 1);

  logic [c_TMO_W-1:0] r_tmo_cnt;
  logic               r_err;

  assign w_tmo_hit = (r_state == WAIT_DONE) && !eng_done &&
                     (r_tmo_cnt == c_TMO_W'(TIMEOUT - 1));

  // Count WAIT_DONE cycles; START clears it so every wait starts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo_cnt <= '0;
    end else if (r_state == START) begin
      r_tmo_cnt <= '0;
    end else if (r_state == WAIT_DONE) begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end
  end

  // Latch the engine result, or an empty result plus error on expiry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_data <= '0;
      r_err      <= 1'b0;
    end else if ((r_state == WAIT_DONE) && eng_done) begin
      r_rsp_data <= eng_ciphertext;
      r_err      <= 1'b0;
    end else if (w_tmo_hit) begin
      r_rsp_data <= '0;
      r_err      <= 1'b1;
    end
  end

  assign rsp_err = r_err;
`else
  assign w_tmo_hit = 1'b0;

  // Latch the engine result when it reports done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_data <= '0;
    end else if ((r_state == WAIT_DONE) && eng_done) begin
      r_rsp_data <= eng_ciphertext;
    end
  end

  assign rsp_err = 1'b0;
`endif

  assign req_ready     = w_req_ready;
  assign rsp_valid     = (r_state == RESP);
  assign rsp_id        = r_id;
  assign rsp_data      = r_rsp_data;
  assign eng_start     = w_eng_start;
  assign eng_key       = r_key;
  assign eng_plaintext = r_pt;
  assign busy          = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_cipher_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_cipher_sched
// Description : Self-checking bench for cipher_sched with a bit-serial XOR
//               engine behind the eng_* port and a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cipher_sched;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 32;
  localparam int LAT     = 14;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NREQ-1:0]  req_valid;
  logic [NREQ-1:0]  req_ready;
  logic [NREQ*8-1:0] req_key;
  logic [NREQ*8-1:0] req_data;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [1:0]       rsp_id;
  logic [7:0]       rsp_data;
  logic             rsp_err;
  logic             eng_start;
  logic [7:0]       eng_key;
  logic [7:0]       eng_plaintext;
  logic             eng_done;
  logic [7:0]       eng_ciphertext;
  logic             busy;
  logic             kill;

  always #5 clk = ~clk;

  cipher_sched #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_key(req_key), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .eng_start(eng_start), .eng_key(eng_key), .eng_plaintext(eng_plaintext),
    .eng_done(eng_done), .eng_ciphertext(eng_ciphertext),
    .busy(busy)
  );

  // ---------------- bit-serial XOR engine (active-high reset) -------------
  typedef enum logic [1:0] {E_IDLE, E_LOAD, E_BIT, E_DONE} eng_st_t;
  eng_st_t    e_st;
  logic [7:0] e_k, e_p, e_res;
  logic [2:0] e_cnt;
  logic       e_rst;
  assign e_rst = ~rst_n;

  always @(posedge clk or posedge e_rst) begin
    if (e_rst) begin
      e_st <= E_IDLE; e_k <= '0; e_p <= '0; e_res <= '0; e_cnt <= '0;
    end else begin
      case (e_st)
        E_IDLE: if (eng_start) e_st <= E_LOAD;
        E_LOAD: begin e_k <= eng_key; e_p <= eng_plaintext; e_cnt <= '0; e_st <= E_BIT; end
        E_BIT: begin
          e_res <= {e_k[0] ^ e_p[0], e_res[7:1]};
          e_k   <= e_k >> 1;
          e_p   <= e_p >> 1;
          e_cnt <= e_cnt + 3'd1;
          if (e_cnt == 3'd7) e_st <= E_DONE;
        end
        default: if (!eng_start) e_st <= E_IDLE;
      endcase
    end
  end
  assign eng_done       = (e_st == E_DONE) && !kill;
  assign eng_ciphertext = e_res;

  // ---------------- check bookkeeping -------------------------------------
  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // ---------------- requester queues --------------------------------------
  logic [7:0] q_key [NREQ][16];
  logic [7:0] q_dat [NREQ][16];
  int         q_hd  [NREQ];
  int         q_tl  [NREQ];
  logic [NREQ-1:0] ready_seen;

  task automatic push(input int i, input logic [7:0] k, input logic [7:0] d);
    q_key[i][q_tl[i]] = k;
    q_dat[i][q_tl[i]] = d;
    q_tl[i]++;
  endtask

  initial begin
    req_valid = '0; req_key = '0; req_data = '0;
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < NREQ; i++) begin
        if (ready_seen[i] && q_hd[i] < q_tl[i]) q_hd[i]++;
        req_valid[i]      = (q_hd[i] < q_tl[i]);
        req_key[i*8 +: 8]  = q_key[i][q_hd[i] % 16];
        req_data[i*8 +: 8] = q_dat[i][q_hd[i] % 16];
      end
    end
  end

  // ---------------- transaction model and per-cycle compare ---------------
  int         cyc = 0;
  bit         m_inflight = 0;
  int         m_ptr = 0;
  int         m_acc, m_lat, m_id, m_rise;
  bit         m_rose, m_err;
  logic [7:0] m_key, m_pt, m_data;
  int         log_n = 0;
  int         log_id [32];
  logic [7:0] log_data [32];
  bit         log_err [32];
  int         log_lat [32];
  int         log_hs [32];
  int         grant_n = 0;
  int         grant_cyc [32];

  always @(negedge clk) begin : p_cmp
    logic [NREQ-1:0] exp_g;
    bit exp_busy, in_resp, exp_start;
    int j, gi;
    cyc++;
    ready_seen = req_ready;
    if (!rst_n) begin
      chk("reset_outputs", {req_ready, rsp_valid, rsp_id, rsp_data, rsp_err,
                            eng_start, eng_key, eng_plaintext, busy}, 64'd0);
      m_inflight = 0;
      m_ptr      = 0;
    end else begin
      exp_g = '0;
      gi    = -1;
      if (!m_inflight) begin
        for (int k = 0; k < NREQ; k++) begin
          j = (m_ptr + k) % NREQ;
          if (gi < 0 && req_valid[j]) begin gi = j; exp_g[j] = 1'b1; end
        end
      end
      chk("req_ready", req_ready, exp_g);
      if (req_ready != '0 && grant_n < 32) begin grant_cyc[grant_n] = cyc; grant_n++; end

      exp_busy  = m_inflight && (cyc > m_acc);
      in_resp   = exp_busy && (cyc >= m_acc + m_lat);
      exp_start = exp_busy && (cyc <= m_acc + m_lat - 3);
      chk("busy", busy, exp_busy);
      chk("rsp_valid", rsp_valid, in_resp);
      chk("eng_start", eng_start, exp_start);
      if (exp_busy) begin
        chk("eng_key", eng_key, m_key);
        chk("eng_plaintext", eng_plaintext, m_pt);
      end
      if (in_resp) begin
        chk("rsp_id", rsp_id, m_id);
        chk("rsp_data", rsp_data, m_data);
        chk("rsp_err", rsp_err, m_err);
      end
      if (m_inflight && rsp_valid && !m_rose) begin m_rose = 1; m_rise = cyc; end
      if (in_resp && rsp_ready) begin
        if (log_n < 32) begin
          log_id[log_n]   = int'(rsp_id);
          log_data[log_n] = rsp_data;
          log_err[log_n]  = rsp_err;
          log_lat[log_n]  = m_rose ? (m_rise - m_acc) : -1;
          log_hs[log_n]   = cyc;
        end
        log_n++;
        m_inflight = 0;
        m_ptr      = (m_id + 1) % NREQ;
      end
      if (gi >= 0) begin
        m_inflight = 1;
        m_acc      = cyc;
        m_id       = gi;
        m_key      = req_key[gi*8 +: 8];
        m_pt       = req_data[gi*8 +: 8];
        m_err      = kill;
        m_data     = kill ? 8'h00 : (m_key ^ m_pt);
        m_lat      = kill ? (3 + TIMEOUT) : LAT;
        m_rose     = 0;
      end
    end
  end

  // ---------------- directed scenarios ------------------------------------
  task automatic cycle();
    @(posedge clk); #2;
  endtask

  task automatic wait_log(input int n, input int budget);
    int t;
    t = 0;
    while (log_n < n && t < budget) begin cycle(); t++; end
    chk("response_wait", (log_n >= n), 1);
  endtask

  initial begin : p_main
    int gb;
    int t;
    rst_n = 1'b0; rsp_ready = 1'b1; kill = 1'b0;
    for (int i = 0; i < NREQ; i++) begin q_hd[i] = 0; q_tl[i] = 0; end
    repeat (3) cycle();
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_eng_start", eng_start, 0);
    rst_n = 1'b1;

    // Single request on requester 0.
    push(0, 8'hA5, 8'h3C);
    wait_log(1, 60);
    chk("s1_id", log_id[0], 0);
    chk("s1_data", log_data[0], 8'h99);
    chk("s1_err", log_err[0], 0);
    chk("s1_latency", log_lat[0], 14);

    // All four valid coming out of reset.
    cycle();
    rst_n = 1'b0;
    push(0, 8'hFF, 8'h0F); push(0, 8'h11, 8'h22);
    push(1, 8'h12, 8'h34); push(2, 8'h56, 8'h78); push(3, 8'h9A, 8'hBC);
    repeat (3) cycle();
    rst_n = 1'b1;
    wait_log(6, 200);
    chk("s2_id0", log_id[1], 0); chk("s2_data0", log_data[1], 8'hF0);
    chk("s2_id1", log_id[2], 1); chk("s2_data1", log_data[2], 8'h26);
    chk("s2_id2", log_id[3], 2); chk("s2_data2", log_data[3], 8'h2E);
    chk("s2_id3", log_id[4], 3); chk("s2_data3", log_data[4], 8'h26);
    chk("s2_id4", log_id[5], 0); chk("s2_data4", log_data[5], 8'h33);

    // Response back-pressure for five cycles.
    gb = grant_n;
    rsp_ready = 1'b0;
    push(1, 8'h81, 8'h18); push(2, 8'hC0, 8'h0C);
    t = 0;
    while (!rsp_valid && t < 60) begin cycle(); t++; end
    chk("s3_resp_seen", rsp_valid, 1);
    for (int k = 0; k < 5; k++) begin
      chk("s3_hold_valid", rsp_valid, 1);
      chk("s3_hold_data", rsp_data, 8'h99);
      chk("s3_hold_start", eng_start, 0);
      chk("s3_hold_ready", req_ready, 0);
      cycle();
    end
    rsp_ready = 1'b1;
    wait_log(8, 60);
    chk("s3_id_a", log_id[6], 1);
    chk("s3_id_b", log_id[7], 2);
    chk("s3_data_b", log_data[7], 8'hCC);
    chk("s3_gap", grant_cyc[gb + 1] - log_hs[6], 1);

    // Reset in the middle of WAIT_DONE.
    gb = grant_n;
    push(3, 8'h5A, 8'hC3); push(1, 8'h0F, 8'hF0);
    t = 0;
    while (grant_n == gb && t < 20) begin cycle(); t++; end
    repeat (4) cycle();
    chk("s4_pre_start", eng_start, 1);
    rst_n = 1'b0;
    #1;
    chk("s4_async_outputs", {req_ready, rsp_valid, rsp_id, rsp_data, rsp_err,
                             eng_start, eng_key, eng_plaintext, busy}, 64'd0);
    cycle(); cycle();
    rst_n = 1'b1;
    wait_log(9, 60);
    chk("s4_id", log_id[8], 1);
    chk("s4_data", log_data[8], 8'hFF);

    // Pointer wrap: bring rr_ptr to 1, then only requester 3.
    push(0, 8'h01, 8'h02);
    wait_log(10, 60);
    push(3, 8'h33, 8'h44);
    wait_log(11, 60);
    chk("s5_id3", log_id[10], 3);
    chk("s5_data3", log_data[10], 8'h77);
    push(0, 8'h10, 8'h20); push(3, 8'h30, 8'h40);
    wait_log(13, 100);
    chk("s5_wrap_first", log_id[11], 0);
    chk("s5_wrap_data", log_data[11], 8'h30);
    chk("s5_wrap_second", log_id[12], 3);

`ifdef CIPHER_SCHED_TIMEOUT_EN
    // Engine never reports done.
    kill = 1'b1;
    push(2, 8'hAA, 8'h55);
    wait_log(14, 120);
    chk("s6_err", log_err[13], 1);
    chk("s6_data", log_data[13], 8'h00);
    chk("s6_latency", log_lat[13], 35);
    kill = 1'b0;
`endif

    repeat (3) cycle();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin : p_watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
